// File: rtl/fir_resp_monitor.sv
// fir_resp_monitor: captures a filter's response into a small buffer once the
// output first goes nonzero. It records the signed peaks and the active length,
// and ends the capture on a quiet run, a full buffer, or a trigger timeout.
module fir_resp_monitor #(
  parameter  int unsigned W     = 10,
  parameter  int unsigned DEPTH = 16,
  parameter  int unsigned QUIET = 3,
  parameter  int unsigned TMO   = 32,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] y_in,
  input  logic                start,
  input  logic [AW-1:0]       rd_addr,
  output logic signed [W-1:0] rd_data,
  output logic                busy,
  output logic                done,
  output logic [AW:0]         len,
  output logic signed [W-1:0] peak_max,
  output logic signed [W-1:0] peak_min,
  output logic                timeout,
  output logic                overflow
);

  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TMO + 1);
  localparam int unsigned QW = $clog2(QUIET + 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARMED   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  // Peaks start at the opposite extremes, so the first sample sets both.
  localparam logic signed [W-1:0] PMAX_INIT = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [W-1:0] PMIN_INIT = {1'b0, {(W-1){1'b1}}};

  logic [1:0]         state_q, state_d;
  logic [CW-1:0]      wcnt_q, wcnt_d;
  logic [CW-1:0]      len_q, len_d;
  logic signed [W-1:0] pmax_q, pmax_d;
  logic signed [W-1:0] pmin_q, pmin_d;
  logic               timeout_q, timeout_d;
  logic               overflow_q, overflow_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic [QW-1:0]      zrun_q, zrun_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic signed [W-1:0] rd_data_q;

  logic               we_c;
  logic [AW-1:0]      waddr_c;
  logic               y_nz_c;

  logic signed [W-1:0] mem [DEPTH];

  // Next-state and result update; start overrides everything else.
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    len_d      = len_q;
    pmax_d     = pmax_q;
    pmin_d     = pmin_q;
    timeout_d  = timeout_q;
    overflow_d = overflow_q;
    tmo_d      = tmo_q;
    zrun_d     = zrun_q;
    we_c       = 1'b0;
    waddr_c    = wcnt_q[AW-1:0];
    y_nz_c     = (y_in != '0);

    if (start) begin
      state_d    = S_ARMED;
      wcnt_d     = '0;
      len_d      = '0;
      pmax_d     = PMAX_INIT;
      pmin_d     = PMIN_INIT;
      timeout_d  = 1'b0;
      overflow_d = 1'b0;
      tmo_d      = '0;
      zrun_d     = '0;
    end else begin
      case (state_q)
        S_ARMED: begin
          if (y_nz_c) begin
            we_c    = 1'b1;
            waddr_c = '0;
            wcnt_d  = CW'(1);
            len_d   = CW'(1);
            zrun_d  = '0;
            if (y_in > pmax_q) pmax_d = y_in;
            if (y_in < pmin_q) pmin_d = y_in;
            state_d = S_CAPTURE;
          end else if (tmo_q == TW'(TMO - 1)) begin
            timeout_d = 1'b1;
            state_d   = S_DONE;
          end else begin
            tmo_d = tmo_q + TW'(1);
          end
        end
        S_CAPTURE: begin
          we_c   = 1'b1;
          wcnt_d = wcnt_q + CW'(1);
          if (y_in > pmax_q) pmax_d = y_in;
          if (y_in < pmin_q) pmin_d = y_in;
          if (y_nz_c) begin
            len_d  = wcnt_q + CW'(1);
            zrun_d = '0;
          end else begin
            zrun_d = zrun_q + QW'(1);
          end
          // Quiet wins over a simultaneous full buffer.
          if (zrun_d == QW'(QUIET)) begin
            state_d = S_DONE;
          end else if (wcnt_d == CW'(DEPTH)) begin
            overflow_d = 1'b1;
            state_d    = S_DONE;
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d == S_ARMED) || (state_d == S_CAPTURE);
    done_d = (state_d == S_DONE);
  end

  // State and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      len_q      <= '0;
      pmax_q     <= '0;
      pmin_q     <= '0;
      timeout_q  <= 1'b0;
      overflow_q <= 1'b0;
      tmo_q      <= '0;
      zrun_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      len_q      <= len_d;
      pmax_q     <= pmax_d;
      pmin_q     <= pmin_d;
      timeout_q  <= timeout_d;
      overflow_q <= overflow_d;
      tmo_q      <= tmo_d;
      zrun_q     <= zrun_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Capture buffer; contents are left unreset and are gated on read instead.
  always_ff @(posedge clk) begin
    if (we_c) mem[waddr_c] <= y_in;
  end

  // Registered read port; addresses not yet written this capture return 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q <= '0;
    end else if ({1'b0, rd_addr} < wcnt_q) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

  assign rd_data  = rd_data_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign len      = len_q;
  assign peak_max = pmax_q;
  assign peak_min = pmin_q;
  assign timeout  = timeout_q;
  assign overflow = overflow_q;

endmodule
